// File: rtl/seg7_card_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_card_decoder_if
// Event output channel of the 7-segment card decoder.
//   out_valid  producer -> consumer  an event is held on the out_* signals
//   out_ready  consumer -> producer  consumer accepts the held event
//   out_idx    producer -> consumer  display number 0..5
//   out_card   producer -> consumer  decoded card code (4'hF on error)
//   out_err    producer -> consumer  pattern was not a legal card glyph
//   out_value  producer -> consumer  baccarat point value (SEG7DEC_VALUE_EN only)
// Modports: master = decoder side, slave = consumer side.
// Optional feature macro: SEG7DEC_VALUE_EN
// -----------------------------------------------------------------------------
interface seg7_card_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [3:0] out_card;
  logic       out_err;
`ifdef SEG7DEC_VALUE_EN
  logic [3:0] out_value;

  modport master (
    output out_valid, out_idx, out_card, out_err, out_value,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_idx, out_card, out_err, out_value,
    output out_ready
  );
`else
  modport master (
    output out_valid, out_idx, out_card, out_err,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_idx, out_card, out_err,
    output out_ready
  );
`endif
endinterface

// File: rtl/seg7_card_decoder.sv
// -----------------------------------------------------------------------------
// seg7_card_decoder
// Watches the six active-low 7-segment card displays, debounces each one, and
// reports every display whose settled pattern differs from the last value
// reported for it, as a decoded card code on a valid/ready channel.
//
// Parameters:
//   STABLE_CYCLES  consecutive unchanged cycles before a pattern is settled (1..15)
// Ports:
//   slow_clock     sole clock, rising edge
//   reset          synchronous, active-high
//   HEX0..HEX5     active-low segment patterns, bit 6 = g, bit 0 = a
//   out_if         event channel (master side): valid/ready, idx, card, err
//                  and out_value when SEG7DEC_VALUE_EN is defined
// Optional feature macro: SEG7DEC_VALUE_EN (adds registered out_value)
// -----------------------------------------------------------------------------
module seg7_card_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                       slow_clock,
  input  logic                       reset,
  input  logic [6:0]                 HEX0,
  input  logic [6:0]                 HEX1,
  input  logic [6:0]                 HEX2,
  input  logic [6:0]                 HEX3,
  input  logic [6:0]                 HEX4,
  input  logic [6:0]                 HEX5,
  seg7_card_decoder_if.master        out_if
);

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);
  localparam logic [6:0] LP_BLANK  = 7'b1111111;

  // Returns {err, card}; any pattern outside the glyph set decodes to err/4'hF.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1111111: res = {1'b0, 4'd0};
      7'b0001000: res = {1'b0, 4'd1};
      7'b0100100: res = {1'b0, 4'd2};
      7'b0110000: res = {1'b0, 4'd3};
      7'b0011001: res = {1'b0, 4'd4};
      7'b0010010: res = {1'b0, 4'd5};
      7'b0000010: res = {1'b0, 4'd6};
      7'b1111000: res = {1'b0, 4'd7};
      7'b0000000: res = {1'b0, 4'd8};
      7'b0010000: res = {1'b0, 4'd9};
      7'b1000000: res = {1'b0, 4'd10};
      7'b1100001: res = {1'b0, 4'd11};
      7'b0011000: res = {1'b0, 4'd12};
      7'b0001001: res = {1'b0, 4'd13};
      default:    res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

`ifdef SEG7DEC_VALUE_EN
  // Face cards, tens, blanks and errors are all worth zero points.
  function automatic logic [3:0] f_value(input logic [3:0] card);
    return (card >= 4'd1 && card <= 4'd9) ? card : 4'd0;
  endfunction
`endif

  logic [6:0] w_hex [6];
  assign w_hex[0] = HEX0;
  assign w_hex[1] = HEX1;
  assign w_hex[2] = HEX2;
  assign w_hex[3] = HEX3;
  assign w_hex[4] = HEX4;
  assign w_hex[5] = HEX5;

  // ---------------------------------------------------------------------------
  // Per-display debounce
  // ---------------------------------------------------------------------------
  logic [6:0] r_cand [6];
  logic [3:0] r_cnt  [6];
  logic [5:0] w_stable;

  // NOTE: every element of these small register arrays has a defined reset
  // value; the post-reset "all blank, all settled" state is what keeps blank
  // displays from producing events, so they cannot be left as plain memory.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        r_cand[i] <= LP_BLANK;
        r_cnt[i]  <= LP_STABLE;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_hex[i] != r_cand[i]) begin
          r_cand[i] <= w_hex[i];
          r_cnt[i]  <= '0;
        end else if (r_cnt[i] != LP_STABLE) begin
          r_cnt[i]  <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_stable[i] = (r_cnt[i] == LP_STABLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin scanner
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_idx;
  logic [2:0] w_idx_next;
  logic       w_hit;
  logic       w_load;
  logic       w_advance;
  logic       w_release;
  logic [4:0] w_dec;
  logic [6:0] r_rep [6];

  logic       r_out_valid;
  logic [2:0] r_out_idx;
  logic [3:0] r_out_card;
  logic       r_out_err;

  assign w_idx_next = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
  assign w_hit      = w_stable[r_idx] && (r_cand[r_idx] != r_rep[r_idx]);
  assign w_dec      = f_decode(r_cand[r_idx]);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge slow_clock) begin
    if (reset) r_state <= ST_SCAN;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_hit) begin
          w_load       = 1'b1;
          w_next_state = ST_EMIT;
        end else begin
          w_advance    = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_if.out_ready) begin
          w_release    = 1'b1;
          w_advance    = 1'b1;
          w_next_state = ST_SCAN;
        end
      end
      default: w_next_state = ST_SCAN;
    endcase
  end

  // The event is captured once in SCAN and held untouched through EMIT, so
  // display changes during a stall only affect r_cand, never the outputs.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_card  <= '0;
      r_out_err   <= 1'b0;
      for (int i = 0; i < 6; i++) r_rep[i] <= LP_BLANK;
    end else begin
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_idx    <= r_idx;
        r_out_card   <= w_dec[3:0];
        r_out_err    <= w_dec[4];
        r_rep[r_idx] <= r_cand[r_idx];
      end
      if (w_release) r_out_valid <= 1'b0;
      if (w_advance) r_idx       <= w_idx_next;
    end
  end

  assign out_if.out_valid = r_out_valid;
  assign out_if.out_idx   = r_out_idx;
  assign out_if.out_card  = r_out_card;
  assign out_if.out_err   = r_out_err;

`ifdef SEG7DEC_VALUE_EN
  logic [3:0] r_out_value;

  always_ff @(posedge slow_clock) begin
    if (reset)       r_out_value <= '0;
    else if (w_load) r_out_value <= f_value(w_dec[3:0]);
  end

  assign out_if.out_value = r_out_value;
`endif

endmodule

// File: tb/tb_seg7_card_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_card_decoder
// Directed bench for seg7_card_decoder (STABLE_CYCLES = 4). Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_card_decoder;

  logic       slow_clock = 1'b0;
  logic       reset      = 1'b1;
  logic [6:0] hex [6];

  int n_checks = 0;
  int n_errors = 0;

  seg7_card_decoder_if bus();

  seg7_card_decoder #(.STABLE_CYCLES(4)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .HEX0       (hex[0]),
    .HEX1       (hex[1]),
    .HEX2       (hex[2]),
    .HEX3       (hex[3]),
    .HEX4       (hex[4]),
    .HEX5       (hex[5]),
    .out_if     (bus)
  );

  always #5 slow_clock = ~slow_clock;

  // Waits (bounded) until out_valid is seen high at a falling edge.
  task automatic wait_valid(input int max_cycles, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < max_cycles && !ok) begin
      @(negedge slow_clock);
      n++;
      if (bus.out_valid === 1'b1) ok = 1'b1;
    end
  endtask

  // Blanks all displays and applies one reset edge; returns at the falling
  // edge right after the first post-reset rising edge.
  task automatic do_reset();
    @(negedge slow_clock);
    for (int i = 0; i < 6; i++) hex[i] = 7'h7F;
    reset = 1'b1;
    @(negedge slow_clock);
    reset = 1'b0;
    @(negedge slow_clock);
  endtask

  task automatic test_reset();
    int vcount;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) hex[i] = 7'h7F;
    reset = 1'b1;
    repeat (3) @(negedge slow_clock);
    n_checks++;
    if ({bus.out_valid, bus.out_idx, bus.out_card, bus.out_err} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b idx=%0d card=%0d err=%b expected all zero",
               bus.out_valid, bus.out_idx, bus.out_card, bus.out_err);
    end
    reset = 1'b0;
    vcount = 0;
    repeat (50) begin
      @(negedge slow_clock);
      if (bus.out_valid !== 1'b0) vcount++;
    end
    n_checks++;
    if (vcount !== 0) begin
      n_errors++;
      $display("FAIL blank_no_event: got %0d valid cycles expected 0", vcount);
    end
  endtask

  task automatic test_single_event();
    int n; bit ok; int vcount;
    bus.out_ready = 1'b1;
    @(negedge slow_clock);
    hex[2] = 7'b0001000;
    wait_valid(30, n, ok);
    n_checks++;
    if (!ok || n < 6 || n > 11) begin
      n_errors++;
      $display("FAIL single_latency: got ok=%b cycles=%0d expected 6..11", ok, n);
    end
    n_checks++;
    if ({bus.out_idx, bus.out_card, bus.out_err} !== {3'd2, 4'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL single_event: got idx=%0d card=%0d err=%b expected idx=2 card=1 err=0",
               bus.out_idx, bus.out_card, bus.out_err);
    end
    vcount = 0;
    repeat (20) begin
      @(negedge slow_clock);
      if (bus.out_valid !== 1'b0) vcount++;
    end
    n_checks++;
    if (vcount !== 0) begin
      n_errors++;
      $display("FAIL single_once: got %0d extra valid cycles expected 0", vcount);
    end
  endtask

  task automatic test_glitch();
    int vcount;
    bus.out_ready = 1'b1;
    @(negedge slow_clock);
    hex[0] = 7'b0100100;
    repeat (2) @(negedge slow_clock);
    hex[0] = 7'h7F;
    vcount = 0;
    repeat (30) begin
      @(negedge slow_clock);
      if (bus.out_valid !== 1'b0) vcount++;
    end
    n_checks++;
    if (vcount !== 0) begin
      n_errors++;
      $display("FAIL glitch: got %0d valid cycles expected 0", vcount);
    end
  endtask

  task automatic test_stall();
    int n; bit ok; int bad;
    do_reset();
    bus.out_ready = 1'b0;
    hex[0] = 7'b1111000;
    hex[3] = 7'b0001001;
    wait_valid(30, n, ok);
    // Scan pointer is at 0 exactly when both displays settle: minimum latency.
    n_checks++;
    if (!ok || n !== 6) begin
      n_errors++;
      $display("FAIL stall_latency: got ok=%b cycles=%0d expected 6", ok, n);
    end
    n_checks++;
    if ({bus.out_idx, bus.out_card, bus.out_err} !== {3'd0, 4'd7, 1'b0}) begin
      n_errors++;
      $display("FAIL stall_first: got idx=%0d card=%0d err=%b expected idx=0 card=7 err=0",
               bus.out_idx, bus.out_card, bus.out_err);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge slow_clock);
      if (c == 5) hex[0] = 7'b0000000;
      if ({bus.out_valid, bus.out_idx, bus.out_card, bus.out_err} !== {1'b1, 3'd0, 4'd7, 1'b0})
        bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL stall_hold: got %0d changed cycles expected 0", bad);
    end
    bus.out_ready = 1'b1;
    wait_valid(20, n, ok);
    n_checks++;
    if (!ok || {bus.out_idx, bus.out_card, bus.out_err} !== {3'd3, 4'd13, 1'b0}) begin
      n_errors++;
      $display("FAIL stall_second: got ok=%b idx=%0d card=%0d err=%b expected idx=3 card=13 err=0",
               ok, bus.out_idx, bus.out_card, bus.out_err);
    end
    wait_valid(20, n, ok);
    n_checks++;
    if (!ok || {bus.out_idx, bus.out_card, bus.out_err} !== {3'd0, 4'd8, 1'b0}) begin
      n_errors++;
      $display("FAIL stall_change_kept: got ok=%b idx=%0d card=%0d err=%b expected idx=0 card=8 err=0",
               ok, bus.out_idx, bus.out_card, bus.out_err);
    end
  endtask

  task automatic test_decode_table();
    logic [6:0] pat [15];
    logic [3:0] exp_card [15];
    logic       exp_err;
    int n; bit ok;
    pat      = '{7'h08, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                 7'h10, 7'h40, 7'h61, 7'h18, 7'h09, 7'h06, 7'h7F};
    exp_card = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'hF, 4'd0};
    bus.out_ready = 1'b1;
    @(negedge slow_clock);
    for (int k = 0; k < 15; k++) begin
      hex[4]  = pat[k];
      exp_err = (exp_card[k] == 4'hF);
      wait_valid(30, n, ok);
      n_checks++;
      if (!ok || {bus.out_idx, bus.out_card, bus.out_err} !== {3'd4, exp_card[k], exp_err}) begin
        n_errors++;
        $display("FAIL decode_%02h: got ok=%b idx=%0d card=%0d err=%b expected idx=4 card=%0d err=%b",
                 pat[k], ok, bus.out_idx, bus.out_card, bus.out_err, exp_card[k], exp_err);
      end
`ifdef SEG7DEC_VALUE_EN
      n_checks++;
      if (bus.out_value !== ((exp_card[k] >= 1 && exp_card[k] <= 9) ? exp_card[k] : 4'd0)) begin
        n_errors++;
        $display("FAIL value_%02h: got %0d", pat[k], bus.out_value);
      end
`endif
    end
  endtask

  task automatic test_error_and_ten();
    int n; bit ok;
    bus.out_ready = 1'b1;
    @(negedge slow_clock);
    hex[5] = 7'b0000110;
    wait_valid(30, n, ok);
    n_checks++;
    if (!ok || {bus.out_idx, bus.out_card, bus.out_err} !== {3'd5, 4'hF, 1'b1}) begin
      n_errors++;
      $display("FAIL error_glyph: got ok=%b idx=%0d card=%0h err=%b expected idx=5 card=f err=1",
               ok, bus.out_idx, bus.out_card, bus.out_err);
    end
    hex[5] = 7'b1000000;
    wait_valid(30, n, ok);
    n_checks++;
    if (!ok || {bus.out_idx, bus.out_card, bus.out_err} !== {3'd5, 4'd10, 1'b0}) begin
      n_errors++;
      $display("FAIL ten_glyph: got ok=%b idx=%0d card=%0d err=%b expected idx=5 card=10 err=0",
               ok, bus.out_idx, bus.out_card, bus.out_err);
    end
`ifdef SEG7DEC_VALUE_EN
    n_checks++;
    if (bus.out_value !== 4'd0) begin
      n_errors++;
      $display("FAIL ten_value: got %0d expected 0", bus.out_value);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n; bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    hex[1] = 7'b0100100;
    hex[2] = 7'b0110000;
    wait_valid(30, n, ok);
    n_checks++;
    if (!ok || n !== 7 || {bus.out_idx, bus.out_card} !== {3'd1, 4'd2}) begin
      n_errors++;
      $display("FAIL b2b_first: got ok=%b cycles=%0d idx=%0d card=%0d expected cycles=7 idx=1 card=2",
               ok, n, bus.out_idx, bus.out_card);
    end
    @(negedge slow_clock);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_gap: got valid=%b expected 0", bus.out_valid);
    end
    @(negedge slow_clock);
    n_checks++;
    if ({bus.out_valid, bus.out_idx, bus.out_card} !== {1'b1, 3'd2, 4'd3}) begin
      n_errors++;
      $display("FAIL b2b_second: got valid=%b idx=%0d card=%0d expected valid=1 idx=2 card=3",
               bus.out_valid, bus.out_idx, bus.out_card);
    end
  endtask

  task automatic test_reset_in_emit();
    int n; bit ok; int vcount;
    do_reset();
    bus.out_ready = 1'b0;
    hex[2] = 7'b0011001;
    wait_valid(30, n, ok);
    n_checks++;
    if (!ok || {bus.out_idx, bus.out_card} !== {3'd2, 4'd4}) begin
      n_errors++;
      $display("FAIL emit_before_reset: got ok=%b idx=%0d card=%0d expected idx=2 card=4",
               ok, bus.out_idx, bus.out_card);
    end
    repeat (3) @(negedge slow_clock);
    reset = 1'b1;
    @(negedge slow_clock);
    n_checks++;
    if ({bus.out_valid, bus.out_idx, bus.out_card, bus.out_err} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_in_emit: got v=%b idx=%0d card=%0d err=%b expected all zero",
               bus.out_valid, bus.out_idx, bus.out_card, bus.out_err);
    end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    wait_valid(30, n, ok);
    n_checks++;
    if (!ok || {bus.out_idx, bus.out_card, bus.out_err} !== {3'd2, 4'd4, 1'b0}) begin
      n_errors++;
      $display("FAIL rereport: got ok=%b idx=%0d card=%0d err=%b expected idx=2 card=4 err=0",
               ok, bus.out_idx, bus.out_card, bus.out_err);
    end
    vcount = 0;
    repeat (20) begin
      @(negedge slow_clock);
      if (bus.out_valid !== 1'b0) vcount++;
    end
    n_checks++;
    if (vcount !== 0) begin
      n_errors++;
      $display("FAIL rereport_once: got %0d extra valid cycles expected 0", vcount);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) hex[i] = 7'h7F;
    test_reset();
    test_single_event();
    test_glitch();
    test_stall();
    test_decode_table();
    test_error_and_ten();
    test_back_to_back();
    test_reset_in_emit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
